// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback and drives datapath enables.
// Optional jump support is compiled in when MC_CTRL_JUMP_EN is defined.
module multicycle_ctrl_fsm #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero_in,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             instr_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [3:0]       state_out,
    output logic [CNT_W-1:0] retired,
    output logic             illegal_op,
    output logic             mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
`ifdef MC_CTRL_JUMP_EN
        S_JUMP   = 4'd11,
`endif
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
`ifdef MC_CTRL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'h02;
`endif

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  retired_reg, retired_next;
    logic              illegal_reg, illegal_next;
    logic              timeout_reg, timeout_next;
    logic              wait_limit;
    logic              mem_wait;

    // The current waiting cycle is the last one allowed before giving up.
    assign wait_limit = (wait_cnt_reg == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            retired_reg  <= '0;
            illegal_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            retired_reg  <= retired_next;
            illegal_reg  <= illegal_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        illegal_next = illegal_reg;
        timeout_next = timeout_reg;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        instr_write  = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;

        // Outputs are forced low for the whole reset pulse, dropping any in-flight request.
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        instr_write = 1'b1;
                        pc_write    = 1'b1;
                        state_next  = S_DECODE;
                    end else if (wait_limit) begin
                        state_next   = S_HALT;
                        timeout_next = 1'b1;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_RTYPE:     state_next = S_EXEC;
                        OP_BEQ:       state_next = S_BRANCH;
                        OP_ADDI:      state_next = S_ADDIEX;
`ifdef MC_CTRL_JUMP_EN
                        OP_J:         state_next = S_JUMP;
`endif
                        default: begin
                            state_next   = S_HALT;
                            illegal_next = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_next = S_MEMWB;
                    end else if (wait_limit) begin
                        state_next   = S_HALT;
                        timeout_next = 1'b1;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_next = S_FETCH;
                    end else if (wait_limit) begin
                        state_next   = S_HALT;
                        timeout_next = 1'b1;
                    end
                end
                S_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b10;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b01;
                    pc_src     = 2'b01;
                    pc_write   = zero_in;
                    state_next = S_FETCH;
                end
                S_ADDIEX: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    state_next = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    state_next = S_FETCH;
                end
`ifdef MC_CTRL_JUMP_EN
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_write   = 1'b1;
                    state_next = S_FETCH;
                end
`endif
                S_HALT: begin
                    state_next = S_HALT;
                end
                default: begin
                    state_next = S_HALT;
                end
            endcase
        end

        mem_wait = mem_req & ~mem_ready;
        // Counter only survives while still waiting in the same state; any exit clears it.
        wait_cnt_next = (mem_wait && (state_next == state_reg)) ? wait_cnt_reg + 1'b1 : '0;
        retired_next  = ((state_next == S_FETCH) && (state_reg != S_FETCH) && (state_reg != S_HALT))
                        ? retired_reg + 1'b1 : retired_reg;
    end

    assign state_out   = state_reg;
    assign retired     = retired_reg;
    assign illegal_op  = illegal_reg;
    assign mem_timeout = timeout_reg;

endmodule
